// File: rtl/counter_b32_checker_if.sv
// counter_b32_checker_if: control, observation and result signals of the nibble-lane counter checker.
interface counter_b32_checker_if #(
    parameter int LANES = 8,
    parameter int CNT_W = 16
);
    logic                 chk_start;
    logic                 chk_clear;
    logic                 chk_enable;
    logic [1:0]           chk_mode;
    logic [4*LANES-1:0]   chk_D;
    logic [4*LANES-1:0]   obs_Q;
    logic [LANES-1:0]     obs_rco;
    logic [LANES-1:0]     obs_load;
    logic                 chk_err;
    logic [LANES-1:0]     chk_err_lane;
    logic [CNT_W-1:0]     chk_err_cnt;
    logic [CNT_W-1:0]     chk_rco_cnt;
    logic                 chk_busy;
    logic                 chk_halted;

    modport master (
        output chk_start, chk_clear, chk_enable, chk_mode, chk_D, obs_Q, obs_rco, obs_load,
        input  chk_err, chk_err_lane, chk_err_cnt, chk_rco_cnt, chk_busy, chk_halted
    );

    modport slave (
        input  chk_start, chk_clear, chk_enable, chk_mode, chk_D, obs_Q, obs_rco, obs_load,
        output chk_err, chk_err_lane, chk_err_cnt, chk_rco_cnt, chk_busy, chk_halted
    );
endinterface

// File: rtl/counter_b32_checker.sv
// counter_b32_checker: predicts the nibble-lane counter one cycle ahead and flags per-lane mismatches.
module counter_b32_checker #(
    parameter int LANES     = 8,
    parameter int CNT_W     = 16,
    parameter int ERR_LIMIT = 16
) (
    input logic                  chk_clk,
    input logic                  chk_reset,
    counter_b32_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(ERR_LIMIT);

    state_t               r_state, w_state_nxt;
    logic                 r_pred_valid;
    logic [4*LANES-1:0]   r_pred_q, w_pred_q;
    logic [LANES-1:0]     r_pred_rco, w_pred_rco;
    logic [LANES-1:0]     r_pred_load, w_pred_load;
    logic [LANES-1:0]     w_mis;
    logic                 r_err;
    logic [LANES-1:0]     r_err_lane;
    logic [CNT_W-1:0]     r_err_cnt, w_err_cnt_nxt;
    logic [CNT_W-1:0]     r_rco_cnt, w_rco_cnt_nxt;
    logic                 w_cmp;

    assign w_cmp = (r_state == CHECK) && r_pred_valid;

    // Prediction is taken from the observed Q so a single fault cannot cascade.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] w_q, w_d;
        assign w_q = bus.obs_Q[4*l +: 4];
        assign w_d = bus.chk_D[4*l +: 4];
        assign w_pred_q[4*l +: 4] = !bus.chk_enable       ? w_q :
                                    bus.chk_mode == 2'b00 ? w_q + 4'd1 :
                                    bus.chk_mode == 2'b01 ? w_q - 4'd1 :
                                    bus.chk_mode == 2'b10 ? w_q - 4'd3 : w_d;
        assign w_pred_rco[l] = bus.chk_enable &&
                               (bus.chk_mode == 2'b00 ? w_q == 4'hF :
                                bus.chk_mode == 2'b01 ? w_q == 4'h0 :
                                bus.chk_mode == 2'b10 ? w_q < 4'd3 : 1'b0);
        assign w_pred_load[l] = bus.chk_enable && bus.chk_mode == 2'b11;
        assign w_mis[l] = w_cmp && (w_q != r_pred_q[4*l +: 4] ||
                                    bus.obs_rco[l] != r_pred_rco[l] ||
                                    bus.obs_load[l] != r_pred_load[l]);
    end

    assign w_err_cnt_nxt = (|w_mis && r_err_cnt != CNT_MAX) ? r_err_cnt + CNT_W'(1) : r_err_cnt;
    assign w_rco_cnt_nxt = (w_cmp && |bus.obs_rco && r_rco_cnt != CNT_MAX) ? r_rco_cnt + CNT_W'(1) : r_rco_cnt;

    always_comb begin
        w_state_nxt = bus.chk_clear                                           ? IDLE  :
                      (r_state == IDLE && bus.chk_start)                      ? CHECK :
                      (r_state == CHECK && |w_mis && w_err_cnt_nxt == LIMIT) ? HALT  : r_state;
    end

    always_ff @(posedge chk_clk or posedge chk_reset) begin
        if (chk_reset) begin
            r_state      <= IDLE;
            r_pred_valid <= 1'b0;
            r_pred_q     <= '0;
            r_pred_rco   <= '0;
            r_pred_load  <= '0;
            r_err        <= 1'b0;
            r_err_lane   <= '0;
            r_err_cnt    <= '0;
            r_rco_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pred_valid <= !bus.chk_clear && r_state == CHECK;
            r_pred_q     <= w_pred_q;
            r_pred_rco   <= w_pred_rco;
            r_pred_load  <= w_pred_load;
            r_err        <= !bus.chk_clear && |w_mis;
            r_err_lane   <= bus.chk_clear ? '0 : w_mis;
            r_err_cnt    <= bus.chk_clear ? '0 : w_err_cnt_nxt;
            r_rco_cnt    <= bus.chk_clear ? '0 : w_rco_cnt_nxt;
        end
    end

    assign bus.chk_err      = r_err;
    assign bus.chk_err_lane = r_err_lane;
    assign bus.chk_err_cnt  = r_err_cnt;
    assign bus.chk_rco_cnt  = r_rco_cnt;
    assign bus.chk_busy     = r_state == CHECK;
    assign bus.chk_halted   = r_state == HALT;
endmodule

// File: tb/tb_counter_b32_checker.sv
// tb_counter_b32_checker: directed vectors against a fault-injectable counter feeding the checker.
module tb_counter_b32_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec  = 0;
    int   miss = 0;

    logic [31:0] iq;
    logic [7:0]  irco, iload;
    logic [31:0] m_q;
    logic [7:0]  m_rco, m_load;

    counter_b32_checker_if #(.LANES(8), .CNT_W(4)) bus ();

    counter_b32_checker #(.LANES(8), .CNT_W(4), .ERR_LIMIT(4)) dut (
        .chk_clk  (clk),
        .chk_reset(rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.obs_Q    = m_q;
    assign bus.obs_rco  = m_rco;
    assign bus.obs_load = m_load;

    // The counter being watched; xor masks corrupt its state/outputs for one cycle.
    function automatic logic [47:0] cnt_next(input logic [31:0] q, input logic en,
                                             input logic [1:0] md, input logic [31:0] d);
        logic [31:0] nq;
        logic [7:0]  r, ld;
        logic [3:0]  v;
        nq = q;
        r  = '0;
        ld = '0;
        if (en) begin
            for (int l = 0; l < 8; l++) begin
                v = q[4*l +: 4];
                case (md)
                    2'b00: begin nq[4*l +: 4] = v + 4'd1; r[l] = (v == 4'd15); end
                    2'b01: begin nq[4*l +: 4] = v - 4'd1; r[l] = (v == 4'd0); end
                    2'b10: begin nq[4*l +: 4] = v - 4'd3; r[l] = (v < 4'd3); end
                    default: begin nq[4*l +: 4] = d[4*l +: 4]; ld[l] = 1'b1; end
                endcase
            end
        end
        return {nq, r, ld};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) {m_q, m_rco, m_load} <= '0;
        else {m_q, m_rco, m_load} <= cnt_next(m_q, bus.chk_enable, bus.chk_mode, bus.chk_D) ^ {iq, irco, iload};
    end

    typedef struct {
        logic        en;
        logic [1:0]  md;
        logic [31:0] d;
        logic [31:0] iq;
        logic [7:0]  ir;
        logic [7:0]  il;
        logic [7:0]  lane;
        logic [3:0]  cnt;
        logic        halt;
    } vec_t;

    vec_t tv[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_err"}, 32'(bus.chk_err), 0);
        chk({nm, "_lane"}, 32'(bus.chk_err_lane), 0);
        chk({nm, "_err_cnt"}, 32'(bus.chk_err_cnt), 0);
        chk({nm, "_rco_cnt"}, 32'(bus.chk_rco_cnt), 0);
        chk({nm, "_busy"}, 32'(bus.chk_busy), 0);
        chk({nm, "_halted"}, 32'(bus.chk_halted), 0);
    endtask

    initial begin
        //            en    md     D             iq            ir     il     lane   cnt   halt
        tv[0]  = '{1'b1, 2'd3, 32'h89ABCDEF, 32'h0,        8'h00, 8'h00, 8'h00, 4'd0, 1'b0};
        tv[1]  = '{1'b1, 2'd2, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd0, 1'b0};
        tv[2]  = '{1'b1, 2'd2, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd0, 1'b0};
        tv[3]  = '{1'b1, 2'd2, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd0, 1'b0};
        tv[4]  = '{1'b1, 2'd0, 32'h0,        32'h00001000, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0};
        tv[5]  = '{1'b1, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h08, 4'd1, 1'b0};
        tv[6]  = '{1'b1, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd1, 1'b0};
        tv[7]  = '{1'b1, 2'd3, 32'h00000000, 32'h0,        8'h00, 8'h00, 8'h00, 4'd1, 1'b0};
        tv[8]  = '{1'b1, 2'd1, 32'h0,        32'h0,        8'h01, 8'h00, 8'h00, 4'd1, 1'b0};
        tv[9]  = '{1'b1, 2'd1, 32'h0,        32'h0,        8'h00, 8'h00, 8'h01, 4'd2, 1'b0};
        tv[10] = '{1'b0, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd2, 1'b0};
        tv[11] = '{1'b0, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd2, 1'b0};
        tv[12] = '{1'b1, 2'd3, 32'h12345678, 32'h0,        8'h00, 8'h80, 8'h00, 4'd2, 1'b0};
        tv[13] = '{1'b1, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h80, 4'd3, 1'b0};
        tv[14] = '{1'b1, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd3, 1'b0};
        tv[15] = '{1'b1, 2'd0, 32'h0,        32'h00000001, 8'h00, 8'h00, 8'h00, 4'd3, 1'b0};
        tv[16] = '{1'b1, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h01, 4'd4, 1'b1};
        tv[17] = '{1'b1, 2'd0, 32'h0,        32'h00000010, 8'h00, 8'h00, 8'h00, 4'd4, 1'b1};
        tv[18] = '{1'b1, 2'd0, 32'h0,        32'h0,        8'h00, 8'h00, 8'h00, 4'd4, 1'b1};

        iq = '0; irco = '0; iload = '0;
        bus.chk_start = 1'b0; bus.chk_clear = 1'b0; bus.chk_enable = 1'b0;
        bus.chk_mode = 2'd0; bus.chk_D = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // count up from 0; the 15->0 wrap is counted one edge after it is seen
        bus.chk_start = 1'b1; bus.chk_enable = 1'b1; bus.chk_mode = 2'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.chk_start = 1'b0;
            chk("up_err", 32'(bus.chk_err), 0);
            chk("up_busy", 32'(bus.chk_busy), 1);
            chk("up_rco_cnt", 32'(bus.chk_rco_cnt), (i >= 16) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 19; i++) begin
            bus.chk_enable = tv[i].en; bus.chk_mode = tv[i].md; bus.chk_D = tv[i].d;
            iq = tv[i].iq; irco = tv[i].ir; iload = tv[i].il;
            tick();
            chk($sformatf("v%0d_lane", i), 32'(bus.chk_err_lane), 32'(tv[i].lane));
            chk($sformatf("v%0d_err", i), 32'(bus.chk_err), 32'(|tv[i].lane));
            chk($sformatf("v%0d_err_cnt", i), 32'(bus.chk_err_cnt), 32'(tv[i].cnt));
            chk($sformatf("v%0d_halted", i), 32'(bus.chk_halted), 32'(tv[i].halt));
        end
        iq = '0; irco = '0; iload = '0;

        bus.chk_clear = 1'b1;
        tick();
        bus.chk_clear = 1'b0;
        chk_all_zero("clear");

        // faults while idle are ignored
        iq = 32'h1;
        tick();
        iq = '0;
        tick();
        tick();
        chk("idle_err", 32'(bus.chk_err), 0);
        chk("idle_err_cnt", 32'(bus.chk_err_cnt), 0);

        bus.chk_start = 1'b1;
        tick();
        bus.chk_start = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            iq = 32'h100;
            tick();
            iq = '0;
            tick();
            chk("pre_rst_err", 32'(bus.chk_err), 1);
            chk("pre_rst_lane", 32'(bus.chk_err_lane), 32'h04);
            chk("pre_rst_cnt", 32'(bus.chk_err_cnt), 32'(k + 1));
        end
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        rst = 1'b0;

        // fault on the start edge is not compared; fault one edge later is
        bus.chk_start = 1'b1; iq = 32'h1;
        tick();
        bus.chk_start = 1'b0; iq = 32'h2;
        chk("resume_busy", 32'(bus.chk_busy), 1);
        chk("resume_err0", 32'(bus.chk_err), 0);
        tick();
        iq = '0;
        chk("resume_err1", 32'(bus.chk_err), 0);
        tick();
        chk("resume_err2", 32'(bus.chk_err), 1);
        chk("resume_lane2", 32'(bus.chk_err_lane), 32'h01);
        chk("resume_cnt2", 32'(bus.chk_err_cnt), 1);
        tick();
        chk("resume_err3", 32'(bus.chk_err), 0);

        // lanes 0..7 counting down raise rco often enough to saturate a 4-bit counter
        bus.chk_clear = 1'b1;
        tick();
        bus.chk_clear = 1'b0; bus.chk_start = 1'b1;
        tick();
        bus.chk_start = 1'b0; bus.chk_mode = 2'd3; bus.chk_D = 32'h76543210;
        tick();
        bus.chk_mode = 2'd1;
        for (int i = 0; i < 40; i++) tick();
        chk("sat_rco_cnt", 32'(bus.chk_rco_cnt), 32'hF);
        chk("sat_err_cnt", 32'(bus.chk_err_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
